// File: rtl/ask_envelope_demodulator_pkg.sv
// Shared widths, mid-scale constant and bit-length lookup for the ASK envelope demodulator.
package ask_envelope_demodulator_pkg;

   localparam int SAMPLE_W  = 12;
   localparam int MAG_W     = 11;
   localparam int MID_SCALE = 2048;
   localparam int LEN_W     = 24;

   // Same bit_rate_sel encoding as the PRBS generator feeding the modulator.
   function automatic logic [LEN_W-1:0] bit_len_lookup(input logic [1:0] sel,
                                                        input int unsigned len0,
                                                        input int unsigned len1,
                                                        input int unsigned len2,
                                                        input int unsigned len3);
      case (sel)
         2'd0:    return LEN_W'(len0);
         2'd1:    return LEN_W'(len1);
         2'd2:    return LEN_W'(len2);
         default: return LEN_W'(len3);
      endcase
   endfunction

endpackage

// File: rtl/ask_peak_window.sv
// Rectifies offset-binary ASK samples and reports the peak magnitude of each window.
module ask_peak_window
   import ask_envelope_demodulator_pkg::*;
#(
   parameter int WIN_LEN = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic [MAG_W-1:0]    envelope,
   output logic                env_valid
);

   localparam int CNT_W = $clog2(WIN_LEN);
   localparam logic [SAMPLE_W:0] MAG_MAX = (SAMPLE_W+1)'((1 << MAG_W) - 1);

   // Offset removal is done signed; the single 2048 result (sample 0) clips to 2047.
   function automatic logic [MAG_W-1:0] rectify_sat(input logic [SAMPLE_W-1:0] s);
      logic signed [SAMPLE_W:0] diff;
      logic        [SAMPLE_W:0] abs_v;
      diff  = $signed({1'b0, s}) - $signed((SAMPLE_W+1)'(MID_SCALE));
      abs_v = (diff < 0) ? (SAMPLE_W+1)'(-diff) : (SAMPLE_W+1)'(diff);
      return (abs_v > MAG_MAX) ? MAG_MAX[MAG_W-1:0] : abs_v[MAG_W-1:0];
   endfunction

   logic [MAG_W-1:0] mag_p0;
   logic [MAG_W-1:0] peak_max_p0;
   logic [MAG_W-1:0] peak;
   logic [CNT_W-1:0] win_cnt;

   always_comb begin
      mag_p0      = rectify_sat(sample_in);
      peak_max_p0 = (mag_p0 > peak) ? mag_p0 : peak;
   end

   // p0 -> p1: peak hold and window close
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak      <= '0;
         win_cnt   <= '0;
         envelope  <= '0;
         env_valid <= 1'b0;
      end else begin
         env_valid <= 1'b0;
         if (sample_valid) begin
            if (win_cnt == CNT_W'(WIN_LEN - 1)) begin
               envelope  <= peak_max_p0;
               env_valid <= 1'b1;
               peak      <= '0;
               win_cnt   <= '0;
            end else begin
               peak      <= peak_max_p0;
               win_cnt   <= win_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ask_envelope_demodulator.sv
// ASK receive path: envelope peak detect, hysteresis slicer, bit timing recovery and lock.
module ask_envelope_demodulator
   import ask_envelope_demodulator_pkg::*;
#(
   parameter int WIN_LEN  = 256,
   parameter int THR_HI   = 1024,
   parameter int THR_LO   = 512,
   parameter int BIT_LEN0 = 5000,
   parameter int BIT_LEN1 = 10000,
   parameter int BIT_LEN2 = 25000,
   parameter int BIT_LEN3 = 50000,
   parameter int MAX_RUN  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic [1:0]          bit_rate_sel,
   output logic [MAG_W-1:0]    envelope,
   output logic                env_valid,
   output logic                level,
   output logic                data_out,
   output logic                data_valid,
   output logic                bit_clock,
   output logic                lock
);

   localparam int RUN_W = $clog2(MAX_RUN + 1);

   logic [LEN_W-1:0] bit_len;
   logic [LEN_W-1:0] half_len;
   logic [LEN_W-1:0] phase;
   logic [LEN_W-1:0] phase_next;
   logic [RUN_W-1:0] run_cnt;
   logic             edge_pend;
   logic             strobe;

   ask_peak_window #(
      .WIN_LEN(WIN_LEN)
   ) u_peak_window (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .envelope     (envelope),
      .env_valid    (env_valid)
   );

   always_comb begin
      bit_len  = bit_len_lookup(bit_rate_sel, BIT_LEN0, BIT_LEN1, BIT_LEN2, BIT_LEN3);
      half_len = bit_len >> 1;
      if (edge_pend)
         phase_next = '0;
      else if (phase >= bit_len - 1'b1)
         phase_next = '0;
      else
         phase_next = phase + 1'b1;
      strobe = sample_valid && !edge_pend && (phase == half_len);
   end

   // p1 -> p2: slicer; an edge stays pending until a valid sample consumes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level     <= 1'b0;
         edge_pend <= 1'b0;
      end else begin
         if (env_valid && (envelope >= MAG_W'(THR_HI)) && !level) begin
            level     <= 1'b1;
            edge_pend <= 1'b1;
         end else if (env_valid && (envelope < MAG_W'(THR_LO)) && level) begin
            level     <= 1'b0;
            edge_pend <= 1'b1;
         end else if (sample_valid) begin
            edge_pend <= 1'b0;
         end
      end
   end

   // p2 -> p3: phase recovery, mid-bit strobe and lock tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase      <= '0;
         bit_clock  <= 1'b0;
         data_out   <= 1'b0;
         data_valid <= 1'b0;
         lock       <= 1'b0;
         run_cnt    <= '0;
      end else begin
         data_valid <= 1'b0;
         if (sample_valid) begin
            phase     <= phase_next;
            bit_clock <= (phase_next < half_len);
            if (edge_pend) begin
               lock    <= 1'b1;
               run_cnt <= '0;
            end else if (strobe) begin
               data_out   <= level;
               data_valid <= 1'b1;
               if (run_cnt < RUN_W'(MAX_RUN))
                  run_cnt <= run_cnt + 1'b1;
               if (run_cnt >= RUN_W'(MAX_RUN - 1))
                  lock <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ask_envelope_demodulator.sv
// Directed bench for ask_envelope_demodulator with shortened window and bit lengths.
module tb_ask_envelope_demodulator;

   logic        clk;
   logic        reset;
   logic [11:0] sample_in;
   logic        sample_valid;
   logic [1:0]  bit_rate_sel;
   logic [10:0] envelope;
   logic        env_valid;
   logic        level;
   logic        data_out;
   logic        data_valid;
   logic        bit_clock;
   logic        lock;

   int n_tests = 0;
   int n_fail  = 0;
   int vcount  = 0;
   int env_cnt = 0;
   int dv_cnt  = 0;
   logic dv_val [64];
   int   dv_at  [64];

   ask_envelope_demodulator #(
      .WIN_LEN (8),
      .THR_HI  (1024),
      .THR_LO  (512),
      .BIT_LEN0(64),
      .BIT_LEN1(96),
      .BIT_LEN2(128),
      .BIT_LEN3(200),
      .MAX_RUN (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .bit_rate_sel (bit_rate_sel),
      .envelope     (envelope),
      .env_valid    (env_valid),
      .level        (level),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .bit_clock    (bit_clock),
      .lock         (lock)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (reset) vcount = 0;
      else if (sample_valid) vcount = vcount + 1;
   end

   always @(negedge clk) begin
      if (reset) begin
         env_cnt = 0;
         dv_cnt  = 0;
      end else begin
         if (env_valid) env_cnt = env_cnt + 1;
         if (data_valid) begin
            if (dv_cnt < 64) begin
               dv_val[dv_cnt] = data_out;
               dv_at[dv_cnt]  = vcount;
            end
            dv_cnt = dv_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int s, input logic v);
      sample_in    = 12'(s);
      sample_valid = v;
      @(negedge clk);
      #1;
   endtask

   task automatic send_n(input int n, input int amp);
      for (int i = 0; i < n; i++)
         drive((i % 2) ? 2048 - amp : 2048 + amp, 1'b1);
   endtask

   task automatic do_reset();
      sample_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   int env_tab [5] = '{1100, 800, 400, 800, 1024};
   int lvl_tab [5] = '{1, 1, 0, 0, 1};

   initial begin
      reset        = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      bit_rate_sel = 2'd0;
      @(negedge clk);
      #1;

      // Reset held with toggling valid samples
      for (int i = 0; i < 10; i++) drive((i % 2) ? 4095 : 0, 1'b1);
      check("rst_envelope",   envelope,   0);
      check("rst_env_valid",  env_valid,  0);
      check("rst_level",      level,      0);
      check("rst_data_out",   data_out,   0);
      check("rst_data_valid", data_valid, 0);
      check("rst_bit_clock",  bit_clock,  0);
      check("rst_lock",       lock,       0);
      reset = 1'b0;

      // Window with an invalid sample of 0 that must be ignored
      drive(2048, 1'b1);
      drive(3000, 1'b1);
      drive(100,  1'b1);
      drive(0,    1'b0);
      for (int i = 0; i < 4; i++) drive(2048, 1'b1);
      check("no_env_early", env_cnt, 0);
      drive(2048, 1'b1);
      check("win1_envelope",  envelope,  1948);
      check("win1_env_valid", env_valid, 1);
      drive(2048, 1'b0);
      check("win1_pulse_end", env_valid, 0);
      check("win1_env_cnt",   env_cnt,   1);
      check("win1_level",     level,     1);
      drive(0, 1'b1);
      for (int i = 0; i < 7; i++) drive(2048, 1'b1);
      check("win2_sat_envelope", envelope, 2047);

      // Partial full-scale window discarded by reset, then hysteresis table
      for (int i = 0; i < 5; i++) drive(0, 1'b1);
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(2048 + env_tab[k], 1'b1);
         for (int i = 0; i < 7; i++) drive(2048, 1'b1);
         check($sformatf("hyst_env%0d", k), envelope, env_tab[k]);
         drive(2048, 1'b0);
         check($sformatf("hyst_level%0d", k), level, lvl_tab[k]);
      end

      // Bit recovery: 1010 at 64 samples/bit
      do_reset();
      bit_rate_sel = 2'd0;
      send_n(64, 1500);
      send_n(64, 100);
      send_n(64, 1500);
      send_n(64, 100);
      check("bits_count", dv_cnt, 4);
      check("bit0_val", dv_val[0], 1);
      check("bit1_val", dv_val[1], 0);
      check("bit2_val", dv_val[2], 1);
      check("bit3_val", dv_val[3], 0);
      check("bit0_at", dv_at[0], 43);
      check("bit_spacing", dv_at[1] - dv_at[0], 64);
      check("bit3_at", dv_at[3], 235);
      check("bits_lock", lock, 1);

      // Constant carrier: lock falls on the 32nd strobe after the last edge
      send_n(2026, 1500);
      check("run31_lock",  lock,   1);
      check("run31_count", dv_cnt, 35);
      send_n(1, 1500);
      check("run32_strobe", data_valid, 1);
      check("run32_lock",   lock,       0);
      check("run32_count",  dv_cnt,     36);
      send_n(64, 1500);
      check("run_sat_lock", lock, 0);
      send_n(64, 100);
      check("relock", lock, 1);

      // Rate change from sel 3 to sel 0 with phase beyond the new length
      bit_rate_sel = 2'd3;
      do_reset();
      send_n(150, 0);
      check("sel3_count",     dv_cnt,    1);
      check("sel3_strobe_at", dv_at[0],  101);
      check("sel3_bit_clock", bit_clock, 0);
      bit_rate_sel = 2'd0;
      send_n(1, 0);
      check("wrap_bit_clock", bit_clock,  1);
      check("wrap_no_strobe", data_valid, 0);
      check("wrap_count",     dv_cnt,     1);
      send_n(32, 0);
      check("post_wrap_count", dv_cnt, 1);
      send_n(1, 0);
      check("post_wrap_strobe", data_valid, 1);
      check("post_wrap_data",   data_out,   0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
